seg7_disp_sched: RTL and testbench

//  Display-source scheduler in front of the 4-digit 7-seg scan driver. Chooses which
//  pre-decoded digit set (speed readout or mode name) the scan driver shows, on clk_1khz.
//  A mode change shows the mode name for a timed hold, then the display returns to speed.

---
 rtl/seg7_pkg.sv | 20 ++
 rtl/seg7_disp_sched_if.sv | 25 ++
 rtl/seg7_disp_sched_tick_timer.sv | 29 ++
 rtl/seg7_disp_sched.sv | 145 ++++++++++++++
 tb/tb_seg7_disp_sched.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared encodings and limits for the 7-segment display-source scheduler.
package seg7_pkg;

  typedef enum logic [1:0] {
    SRC_SPEED = 2'b00,
    SRC_MODE  = 2'b01,
    SRC_FAULT = 2'b10
  } src_e;

  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [1:0] MODE_MAX  = 2'd2;
  localparam logic [3:0] SPEED_MAX = 4'd8;

  // An out-of-range mode or speed code means the upstream decoders cannot be trusted.
  function automatic logic is_fault(input logic [1:0] mode, input logic [3:0] speed_code);
    return (mode > MODE_MAX) || (speed_code > SPEED_MAX);
  endfunction

endpackage

// File: rtl/seg7_disp_sched_if.sv
// Decoder-side inputs and scan-driver-side outputs of the display-source scheduler.
interface seg7_disp_sched_if #(
  parameter int HOLD_MS = 2000
);
  logic [1:0]                       mode;
  logic [3:0]                       speed_code;
  logic [27:0]                      mode_dk;
  logic [27:0]                      speed_dk;
  logic [6:0]                       DK1;
  logic [6:0]                       DK2;
  logic [6:0]                       DK3;
  logic [6:0]                       DK4;
  logic [1:0]                       src;
  logic [$clog2(HOLD_MS+1)-1:0]     hold_left;

  modport master (
    output mode, speed_code, mode_dk, speed_dk,
    input  DK1, DK2, DK3, DK4, src, hold_left
  );

  modport slave (
    input  mode, speed_code, mode_dk, speed_dk,
    output DK1, DK2, DK3, DK4, src, hold_left
  );
endinterface

// File: rtl/seg7_disp_sched_tick_timer.sv
// Loadable down-counter on the 1 kHz tick; saturates at zero instead of wrapping.
module seg7_tick_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt
);

  // Clear beats load beats decrement; decrement stops at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/seg7_disp_sched.sv
// Chooses speed readout, mode name or blinking fault dashes for the 4-digit scan driver.
module seg7_disp_sched
  import seg7_pkg::*;
#(
  parameter int HOLD_MS  = 2000,
  parameter int BLINK_MS = 250
) (
  input  logic              clk_1khz,
  input  logic              rst_n,
  seg7_disp_sched_if.slave  bus
);

  localparam int HW = $clog2(HOLD_MS + 1);
  localparam int BW = $clog2(BLINK_MS + 1);

  src_e          state;
  src_e          nxt;
  logic [1:0]    mode_q;
  logic          blink_ph;
  logic          nxt_ph;
  logic          fault;
  logic          change;
  logic          hold_clr;
  logic          hold_load;
  logic          hold_dec;
  logic          blink_load;
  logic          blink_dec;
  logic [HW-1:0] hold_cnt;
  logic [BW-1:0] blink_cnt;
  logic          hold_zero;
  logic          blink_zero;
  logic [27:0]   dk_q;
  logic [27:0]   nxt_dk;

  seg7_tick_timer #(.W(HW)) u_hold (
    .clk      (clk_1khz),
    .rst_n    (rst_n),
    .clr      (hold_clr),
    .load     (hold_load),
    .load_val (HW'(HOLD_MS - 1)),
    .dec      (hold_dec),
    .cnt      (hold_cnt)
  );

  seg7_tick_timer #(.W(BW)) u_blink (
    .clk      (clk_1khz),
    .rst_n    (rst_n),
    .clr      (1'b0),
    .load     (blink_load),
    .load_val (BW'(BLINK_MS - 1)),
    .dec      (blink_dec),
    .cnt      (blink_cnt)
  );

  assign fault      = is_fault(bus.mode, bus.speed_code);
  assign change     = (bus.mode != mode_q);
  assign hold_zero  = (hold_cnt == '0);
  assign blink_zero = (blink_cnt == '0);

  // Next state, timer controls and the digit set that next state will show.
  always_comb begin
    nxt        = state;
    nxt_ph     = blink_ph;
    hold_clr   = 1'b0;
    hold_load  = 1'b0;
    hold_dec   = 1'b0;
    blink_load = 1'b0;
    blink_dec  = 1'b0;
    case (state)
      SRC_SPEED: begin
        if (fault) begin
          nxt        = SRC_FAULT;
          nxt_ph     = 1'b1;
          blink_load = 1'b1;
          hold_clr   = 1'b1;
        end else if (change) begin
          nxt       = SRC_MODE;
          hold_load = 1'b1;
        end else begin
          nxt = SRC_SPEED;
        end
      end
      SRC_MODE: begin
        if (fault) begin
          nxt        = SRC_FAULT;
          nxt_ph     = 1'b1;
          blink_load = 1'b1;
          hold_clr   = 1'b1;
        end else if (change) begin
          hold_load = 1'b1;
        end else if (hold_zero) begin
          nxt = SRC_SPEED;
        end else begin
          hold_dec = 1'b1;
        end
      end
      SRC_FAULT: begin
        // A mode change seen while faulted is deliberately dropped: exit always shows speed.
        if (!fault) begin
          nxt = SRC_SPEED;
        end else if (blink_zero) begin
          nxt        = SRC_FAULT;
          nxt_ph     = ~blink_ph;
          blink_load = 1'b1;
        end else begin
          blink_dec = 1'b1;
        end
      end
      default: begin
        nxt      = SRC_SPEED;
        hold_clr = 1'b1;
      end
    endcase

    case (nxt)
      SRC_SPEED: nxt_dk = bus.speed_dk;
      SRC_MODE:  nxt_dk = bus.mode_dk;
      SRC_FAULT: nxt_dk = nxt_ph ? {4{SEG_DASH}} : {4{SEG_BLANK}};
      default:   nxt_dk = {4{SEG_BLANK}};
    endcase
  end

  // State, blink phase, mode history and registered digit outputs.
  always_ff @(posedge clk_1khz) begin
    if (!rst_n) begin
      state    <= SRC_SPEED;
      mode_q   <= 2'b00;
      blink_ph <= 1'b0;
      dk_q     <= {4{SEG_BLANK}};
    end else begin
      state    <= nxt;
      mode_q   <= bus.mode;
      blink_ph <= nxt_ph;
      dk_q     <= nxt_dk;
    end
  end

  assign bus.DK1       = dk_q[27:21];
  assign bus.DK2       = dk_q[20:14];
  assign bus.DK3       = dk_q[13:7];
  assign bus.DK4       = dk_q[6:0];
  assign bus.src       = state;
  assign bus.hold_left = hold_cnt;

endmodule

// File: tb/tb_seg7_disp_sched.sv
// Directed plus randomized bench for seg7_disp_sched against a per-tick behavioural model.
module tb_seg7_disp_sched;

  localparam int HOLD_MS  = 4;
  localparam int BLINK_MS = 2;
  localparam logic [27:0] DASHES = {4{7'b1000000}};

  logic clk_1khz = 1'b0;
  logic rst_n    = 1'b0;

  seg7_disp_sched_if #(.HOLD_MS(HOLD_MS)) bus ();

  seg7_disp_sched #(.HOLD_MS(HOLD_MS), .BLINK_MS(BLINK_MS)) dut (
    .clk_1khz (clk_1khz),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  always #5 clk_1khz = ~clk_1khz;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Model: 0 speed shown, 1 mode name shown, 2 fault blink.
  int          m_src  = 0;
  int          m_hold = 0;
  int          m_bcnt = 0;
  bit          m_ph   = 1'b0;
  int          m_mq   = 0;
  logic [27:0] m_dk   = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int  md;
    int  sp;
    bit  flt;
    bit  chg;
    md = int'(bus.mode);
    sp = int'(bus.speed_code);
    if (!rst_n) begin
      m_src = 0; m_hold = 0; m_bcnt = 0; m_ph = 1'b0; m_mq = 0;
      m_dk  = '0;
      return;
    end
    flt = (md == 3) || (sp > 8);
    chg = (md != m_mq);
    if (m_src == 0) begin
      if (flt) begin
        m_src = 2; m_ph = 1'b1; m_bcnt = BLINK_MS - 1;
      end else if (chg) begin
        m_src = 1; m_hold = HOLD_MS - 1;
      end
    end else if (m_src == 1) begin
      if (flt) begin
        m_src = 2; m_hold = 0; m_ph = 1'b1; m_bcnt = BLINK_MS - 1;
      end else if (chg) begin
        m_hold = HOLD_MS - 1;
      end else if (m_hold == 0) begin
        m_src = 0;
      end else begin
        m_hold = m_hold - 1;
      end
    end else begin
      if (!flt) begin
        m_src = 0;
      end else if (m_bcnt == 0) begin
        m_ph = ~m_ph; m_bcnt = BLINK_MS - 1;
      end else begin
        m_bcnt = m_bcnt - 1;
      end
    end
    m_mq = md;
    if (m_src == 0)      m_dk = bus.speed_dk;
    else if (m_src == 1) m_dk = bus.mode_dk;
    else                 m_dk = m_ph ? DASHES : 28'd0;
  endtask

  task automatic tick();
    @(posedge clk_1khz);
    model_edge();
    #1;
    check("src", 32'(bus.src), 32'(m_src));
    check("hold_left", 32'(bus.hold_left), 32'(m_hold));
    check("digits", 32'({bus.DK1, bus.DK2, bus.DK3, bus.DK4}), 32'(m_dk));
    bus.mode_dk  = 28'($urandom);
    bus.speed_dk = 28'($urandom);
  endtask

  initial begin
    bus.mode       = 2'd0;
    bus.speed_code = 4'd0;
    bus.mode_dk    = 28'($urandom);
    bus.speed_dk   = 28'($urandom);

    // Reset, then release into SPEED.
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_digits", 32'({bus.DK1, bus.DK2, bus.DK3, bus.DK4}), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Mode change: name held for HOLD_MS edges, then back to speed.
    bus.mode = 2'd1;
    tick();
    check("hold_start", 32'(bus.hold_left), 32'd3);
    repeat (4) tick();
    check("hold_expired_src", 32'(bus.src), 32'd0);

    // Change mid-hold reloads the hold.
    bus.mode = 2'd2;
    repeat (3) tick();
    bus.mode = 2'd1;
    tick();
    check("hold_reload", 32'(bus.hold_left), 32'd3);
    repeat (4) tick();

    // Bad speed while in MODE goes straight to fault with dashes.
    bus.mode = 2'd0;
    tick();
    bus.speed_code = 4'd9;
    tick();
    check("fault_entry_digits", 32'({bus.DK1, bus.DK2, bus.DK3, bus.DK4}), 32'(DASHES));
    repeat (5) tick();
    bus.speed_code = 4'd0;
    tick();

    // Invalid mode with a mode change and bad speed; recovery shows speed, not the mode name.
    bus.mode       = 2'd3;
    bus.speed_code = 4'd12;
    repeat (3) tick();
    bus.mode       = 2'd1;
    bus.speed_code = 4'd2;
    tick();
    check("fault_exit_src", 32'(bus.src), 32'd0);
    repeat (2) tick();

    // Reset in the middle of a blink.
    bus.speed_code = 4'd10;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    check("reset_mid_fault_src", 32'(bus.src), 32'd0);
    rst_n          = 1'b1;
    bus.mode       = 2'd0;
    bus.speed_code = 4'd0;
    tick();

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) < 12) bus.mode = 2'($urandom_range(0, 3));
      if (bus.speed_code > 4'd8) begin
        if ($urandom_range(0, 99) < 30) bus.speed_code = 4'($urandom_range(0, 8));
      end else if ($urandom_range(0, 99) < 5) begin
        bus.speed_code = 4'($urandom_range(9, 15));
      end else begin
        bus.speed_code = 4'($urandom_range(0, 8));
      end
      if (bus.mode == 2'd3 && $urandom_range(0, 99) < 40) bus.mode = 2'($urandom_range(0, 2));
      rst_n = ($urandom_range(0, 99) < 1) ? 1'b0 : 1'b1;
      tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
